// File: rtl/fifo_flags.sv
// ============================================================================
// fifo_flags
// ----------------------------------------------------------------------------
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow error pulses and a selectable read mode. Any DEPTH >= 2
// is supported. The pointers wrap explicitly at DEPTH-1. They are not masked
// to a power of two.
//
// Parameters
//   DEPTH       number of entries (>= 2, any integer)
//   DATA_WIDTH  word width in bits
//   AFULL_TH    almost_full  when count >= AFULL_TH  (1 .. DEPTH)
//   AEMPTY_TH   almost_empty when count <= AEMPTY_TH (0 .. DEPTH-1)
//   FWFT        0 = registered read (1-cycle latency)
//               1 = first-word fall-through (head word shown while !empty)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset, dominates wr_en / rd_en
//   data_in       write data
//   wr_en         write request, accepted when !full
//   rd_en         read request (pop in FWFT mode), accepted when !empty
//   data_out      read data
//   empty         count == 0
//   full          count == DEPTH
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         number of stored words
//   overflow      one-cycle pulse after a write attempted while full
//   underflow     one-cycle pulse after a read attempted while empty
// ============================================================================
module fifo_flags #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Acceptance looks only at the flags from before the edge. A read in the
    // same cycle does not make room for a write into a full FIFO. A write in
    // the same cycle does not satisfy a read from an empty FIFO.
    logic wr_accept;
    logic rd_accept;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // The pointer wraps explicitly at DEPTH-1 so that depths which are not a
    // power of two still use every entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: the storage array deliberately has no reset. Its contents are only
    // observable through rd_ptr and count, and both of those are reset.
    // Leaving the array out of the reset lets it map onto RAM or a
    // non-resettable register file.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: all state uses non-blocking assignments. Every register then
    // samples the same pre-edge values, which is what the acceptance rule
    // above depends on.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_accept) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy count
    // ------------------------------------------------------------------------
    // When a write and a read are both accepted, the count does not change.
    // The acceptance gating already prevents the count from going above DEPTH
    // or below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status flags, decoded from the registered count
    // ------------------------------------------------------------------------
    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AFULL_TH));
    assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

    // ------------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------------
    // Each pulse is re-evaluated every cycle. One offending request therefore
    // gives one cycle high. Consecutive offending requests give a continuous
    // high.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    // ------------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------------
    generate
        if (FWFT) begin : g_fwft
            // The head word is always visible. It reads as zero when the FIFO
            // is empty, so that stale contents never leak out. rd_en only
            // acknowledges (pops) the word currently shown.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_q;

            // data_q is loaded only on an accepted read. A rejected read, or
            // no read at all, leaves the previous word on data_out.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_accept) begin
                    data_q <= mem[rd_ptr];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

`ifndef SYNTHESIS
    // ------------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------------
    a_count_bounded : assert property (
        @(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH)
    );

    a_wr_ptr_in_range : assert property (
        @(posedge clk) disable iff (rst) wr_ptr <= PTR_W'(DEPTH - 1)
    );

    a_rd_ptr_in_range : assert property (
        @(posedge clk) disable iff (rst) rd_ptr <= PTR_W'(DEPTH - 1)
    );

    a_full_empty_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(full && empty)
    );
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// ============================================================================
// tb_fifo_flags
// ----------------------------------------------------------------------------
// Two fifo_flags instances (registered read and fall-through) share one
// stimulus stream. A queue-based model of the FIFO contents supplies the
// expected count, flags, error pulses and read data for both read modes.
// ============================================================================
`timescale 1ns/1ps

module tb_fifo_flags;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AF_TH = 3;
    localparam int AE_TH = 1;
    // Width of the packed vector {count, empty, full, ae, af, ov, uf, data}.
    localparam int VW    = CW + 6 + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;

    logic [DW-1:0] d0_data_out, d1_data_out;
    logic          d0_empty, d1_empty, d0_full, d1_full;
    logic          d0_af, d1_af, d0_ae, d1_ae;
    logic [CW-1:0] d0_count, d1_count;
    logic          d0_ov, d1_ov, d0_uf, d1_uf;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fifo_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .FWFT(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d0_data_out), .empty(d0_empty), .full(d0_full),
        .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
        .overflow(d0_ov), .underflow(d0_uf)
    );

    fifo_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH), .FWFT(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(d1_data_out), .empty(d1_empty), .full(d1_full),
        .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
        .overflow(d1_ov), .underflow(d1_uf)
    );

    // ------------------------------------------------------------------------
    // Reference model: the stored words kept as a queue (head = oldest)
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout_reg = '0;
    logic          m_ov = 1'b0;
    logic          m_uf = 1'b0;

    // Applies one cycle of stimulus and updates the model at the edge. Control
    // returns 1 ns after the edge, which is when outputs are sampled.
    task automatic tick(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic rs);
        int n;
        bit wa, ra;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_dout_reg = '0;
            m_ov       = 1'b0;
            m_uf       = 1'b0;
        end else begin
            n    = m_q.size();
            wa   = w && (n < DEPTH);
            ra   = r && (n > 0);
            m_ov = w && (n == DEPTH);
            m_uf = r && (n == 0);
            if (ra) m_dout_reg = m_q.pop_front();
            if (wa) m_q.push_back(d);
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [VW-1:0] exp_vec(input bit fwft);
        int n;
        logic [DW-1:0] dv;
        n  = m_q.size();
        dv = fwft ? ((n == 0) ? '0 : m_q[0]) : m_dout_reg;
        return {CW'(n), n == 0, n == DEPTH, n <= AE_TH, n >= AF_TH, m_ov, m_uf, dv};
    endfunction

    function automatic logic [VW-1:0] d0_vec();
        return {d0_count, d0_empty, d0_full, d0_ae, d0_af, d0_ov, d0_uf, d0_data_out};
    endfunction

    function automatic logic [VW-1:0] d1_vec();
        return {d1_count, d1_empty, d1_full, d1_ae, d1_af, d1_ov, d1_uf, d1_data_out};
    endfunction

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [VW-1:0] rv;
        tick(1'b0, '0, 1'b0, 1'b1);
        rst = 1'b0;
        // count=0, empty=1, full=0, ae=1, af=0, ov=0, uf=0, data=0
        rv = {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(0)};
        tests_run++;
        if (d0_vec() !== rv) begin
            tests_failed++;
            $display("FAIL reset_fwft0: got %h want %h", d0_vec(), rv);
        end
        tests_run++;
        if (d1_vec() !== rv) begin
            tests_failed++;
            $display("FAIL reset_fwft1: got %h want %h", d1_vec(), rv);
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] words [4];
        logic [3:0]    ae_exp, af_exp, full_exp;
        words    = '{8'h11, 8'h22, 8'h33, 8'h44};
        ae_exp   = 4'b0001;   // bit i: value after write i+1
        af_exp   = 4'b1100;
        full_exp = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, words[i], 1'b0, 1'b0);
            tests_run++;
            if (d0_count !== CW'(i + 1) || d0_ae !== ae_exp[i] || d0_af !== af_exp[i]
                || d0_full !== full_exp[i]) begin
                tests_failed++;
                $display("FAIL fill_flags[%0d]: count=%0d ae=%b af=%b full=%b want count=%0d ae=%b af=%b full=%b",
                         i, d0_count, d0_ae, d0_af, d0_full, i + 1, ae_exp[i], af_exp[i], full_exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (d0_data_out !== words[i] || d0_vec() !== exp_vec(1'b0)) begin
                tests_failed++;
                $display("FAIL drain_data[%0d]: got %h/%h want %h/%h",
                         i, d0_data_out, d0_vec(), words[i], exp_vec(1'b0));
            end
        end
        idle();
        tests_run++;
        if (d0_empty !== 1'b1 || d1_empty !== 1'b1 || d1_data_out !== '0) begin
            tests_failed++;
            $display("FAIL drain_empty: empty0=%b empty1=%b data1=%h want 1 1 00",
                     d0_empty, d1_empty, d1_data_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) tick(1'b1, DW'((i + 1) * 8'h11), 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (d0_ov !== 1'b1 || d1_ov !== 1'b1 || d0_count !== CW'(4)) begin
            tests_failed++;
            $display("FAIL overflow_pulse: ov0=%b ov1=%b count=%0d want 1 1 4", d0_ov, d1_ov, d0_count);
        end
        idle();
        tests_run++;
        if (d0_ov !== 1'b0 || d1_ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_width: ov0=%b ov1=%b want 0 0", d0_ov, d1_ov);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (d0_data_out !== DW'((i + 1) * 8'h11)) begin
                tests_failed++;
                $display("FAIL overflow_drain[%0d]: got %h want %h", i, d0_data_out, DW'((i + 1) * 8'h11));
            end
        end
        idle();
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prior;
        prior = d0_data_out;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            tests_run++;
            if (d0_uf !== 1'b1 || d1_uf !== 1'b1 || d0_count !== '0
                || d0_data_out !== prior || d1_data_out !== '0) begin
                tests_failed++;
                $display("FAIL underflow[%0d]: uf0=%b uf1=%b count=%0d d0=%h d1=%h want 1 1 0 %h 00",
                         i, d0_uf, d1_uf, d0_count, d0_data_out, d1_data_out, prior);
            end
        end
        idle();
        tests_run++;
        if (d0_uf !== 1'b0 || d1_uf !== 1'b0) begin
            tests_failed++;
            $display("FAIL underflow_end: uf0=%b uf1=%b want 0 0", d0_uf, d1_uf);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 8'h80, 1'b0, 1'b0);
        tick(1'b1, 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, DW'(8'h82 + i), 1'b1, 1'b0);
            tests_run++;
            if (d0_count !== CW'(2) || d0_data_out !== DW'(8'h80 + i)
                || d1_data_out !== DW'(8'h81 + i)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: count=%0d d0=%h d1=%h want 2 %h %h",
                         i, d0_count, d0_data_out, d1_data_out, DW'(8'h80 + i), DW'(8'h81 + i));
            end
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (d0_data_out !== 8'h8B || d0_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back_tail: d0=%h empty=%b want 8b 1", d0_data_out, d0_empty);
        end
        idle();
    endtask

    task automatic test_fwft();
        tick(1'b1, 8'hA5, 1'b0, 1'b0);
        tests_run++;
        if (d1_data_out !== 8'hA5 || d1_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwft_show: data=%h empty=%b want a5 0", d1_data_out, d1_empty);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (d1_data_out !== '0 || d1_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwft_pop: data=%h empty=%b want 00 1", d1_data_out, d1_empty);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] rv;
        for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b1);
        rv = {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DW'(0)};
        tests_run++;
        if (d0_vec() !== rv || d1_vec() !== rv) begin
            tests_failed++;
            $display("FAIL reset_mid: got %h/%h want %h", d0_vec(), d1_vec(), rv);
        end
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        tests_run++;
        if (d1_data_out !== 8'h77 || d0_count !== CW'(1)) begin
            tests_failed++;
            $display("FAIL reset_mid_write: d1=%h count=%0d want 77 1", d1_data_out, d0_count);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        tests_run++;
        if (d0_data_out !== 8'h77 || d0_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_read: d0=%h empty=%b want 77 1", d0_data_out, d0_empty);
        end
        idle();
    endtask

    task automatic test_random();
        int fails_here;
        int phase_w;
        fails_here = 0;
        for (int i = 0; i < 400; i++) begin
            // Alternate between fill-biased, drain-biased and balanced phases
            // so that every occupancy level and both error pulses are reached.
            phase_w = ((i / 40) % 3 == 0) ? 80 : ((i / 40) % 3 == 1) ? 20 : 50;
            tick($urandom_range(0, 99) < phase_w, DW'($urandom),
                 $urandom_range(0, 99) < (100 - phase_w),
                 $urandom_range(0, 149) == 0);
            tests_run++;
            if (d0_vec() !== exp_vec(1'b0) || d1_vec() !== exp_vec(1'b1)) begin
                tests_failed++;
                if (fails_here < 10)
                    $display("FAIL random[%0d]: got %h/%h want %h/%h",
                             i, d0_vec(), d1_vec(), exp_vec(1'b0), exp_vec(1'b1));
                fails_here++;
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO, the successor to the team's basic `fifo`. It adds:
- threshold flags (`almost_full`, `almost_empty`);
- an occupancy count;
- overflow and underflow error pulses;
- a selectable first-word-fall-through read mode;
- support for non-power-of-two depths.

It sits between a producer and a consumer in the same clock domain and is the default buffering primitive for new datapath blocks.

## Interface
- `DEPTH`, 4: number of entries. Must be ≥2; any integer is allowed.
- `DATA_WIDTH`, 8: word width in bits.
- `AFULL_TH`, DEPTH-1: `almost_full` asserts when count ≥ AFULL_TH. Legal range 1..DEPTH.
- `AEMPTY_TH`, 1: `almost_empty` asserts when count ≤ AEMPTY_TH. Legal range 0..DEPTH-1.
- `FWFT`, 0: read mode. 0 = registered read; 1 = first-word fall-through.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in DATA_WIDTH: write data.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `data_out` out DATA_WIDTH: read data.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `almost_full` out 1: count ≥ AFULL_TH.
- `almost_empty` out 1: count ≤ AEMPTY_TH.
- `count` out $clog2(DEPTH+1): number of stored words.
- `overflow` out 1: one-cycle pulse for a rejected write.
- `underflow` out 1: one-cycle pulse for a rejected read.

## Operation
- **Accepted write:** `wr_en && !full`, sampled at the edge. `data_in` is stored at `wr_ptr` and `wr_ptr` advances.
- **Accepted read:** `rd_en && !empty`, sampled at the edge. `rd_ptr` advances.
- **Acceptance rule:** acceptance depends only on the pre-edge flags. A write while `full` is rejected even if a read is accepted in the same cycle. A read while `empty` is rejected even if a write is accepted in the same cycle.
- **Pointer wrap:** both pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1. There is no power-of-two masking.
- **Count update:**
  - +1 for an accepted write alone.
  - -1 for an accepted read alone.
  - Unchanged when both are accepted or neither is.
  - Never exceeds DEPTH and never underflows.
- **Flags:** all four flags are derived combinationally from the registered `count`.
- **`overflow`:** registered. High for exactly the one cycle after an edge where `wr_en && full`. Storage and pointers are untouched by the rejected write.
- **`underflow`:** registered. High for exactly the one cycle after an edge where `rd_en && empty`. `data_out` is unchanged.
- **FWFT=0 (registered read):** on an accepted read, `data_out` is loaded with `mem[rd_ptr]`. Otherwise `data_out` holds its value.
- **FWFT=1 (fall-through):** `data_out` = `mem[rd_ptr]` combinationally whenever `!empty`, and is 0 when `empty`. `rd_en` acts as a "pop" acknowledge of the word currently shown.
- **Reset:** `rst` dominates `wr_en`/`rd_en`. It discards all contents, including when asserted mid-operation.
- **Memory:** not reset; only pointers, count and outputs are.

## Timing
- **Reset values:**
  - `wr_ptr` = `rd_ptr` = 0 and `count` = 0.
  - `empty` = 1, `full` = 0.
  - `almost_empty` = 1, `almost_full` = 0.
  - `overflow` = `underflow` = 0.
  - `data_out` = 0.
- **Write to flags:** `count` and all flags reflect an accepted write or read from the cycle after its edge.
- **FWFT=0 read latency:** 1 cycle. The word is valid on `data_out` after the edge that accepted `rd_en`.
- **FWFT=1 first word:** a write into an empty FIFO appears on `data_out` in the cycle after the write edge, together with `empty` deasserting.
- **FWFT=1 next word:** after a pop, the next word (or 0 if now empty) appears in the cycle after the pop edge.
- **Throughput:** one write and one read per cycle are sustainable indefinitely when 0 < count < DEPTH.
- **Error pulse width:** `overflow` and `underflow` last exactly 1 cycle per offending request. Back-to-back offending cycles give a continuous high.

## Test plan
All scenarios use DEPTH=4, DATA_WIDTH=8, AFULL_TH=3, AEMPTY_TH=1.

1. **Fill, then drain (FWFT=0):** after reset, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
   - `count` steps 1..4.
   - `almost_empty` drops after the 2nd write, `almost_full` rises after the 3rd, `full` rises after the 4th.
   - Then hold `rd_en` for 4 cycles: `data_out` = 0x11, 0x22, 0x33, 0x44, one cycle after each read edge, and `empty` = 1 at the end.
2. **Overflow:** with the FIFO full of 0x11..0x44, assert `wr_en` with 0x55 for 1 cycle.
   - `overflow` pulses for 1 cycle and `count` stays 4.
   - A subsequent drain returns 0x11..0x44 with no 0x55.
3. **Underflow:** with the FIFO empty, assert `rd_en` for 2 cycles.
   - `underflow` is high for 2 cycles and `count` stays 0.
   - `data_out` keeps its prior value (FWFT=0), or 0 (FWFT=1).
4. **Simultaneous read/write and wrap:** at count=2, run 10 cycles of `wr_en`=`rd_en`=1 with an incrementing pattern.
   - `count` stays 2 and the read order matches the write order.
   - The pointers wrap at least twice without corruption.
5. **FWFT=1 fall-through:** write 0xA5 into an empty FIFO.
   - The next cycle shows `data_out` = 0xA5 and `empty` = 0 with no `rd_en`.
   - After a pop, `data_out` = 0 and `empty` = 1.
6. **Reset mid-operation:** at count=3, assert `rst` for 1 cycle together with `wr_en`=1.
   - All outputs return to their reset values and `count` = 0.
   - Writing 0x77 then reading returns 0x77.
